// File: rtl/dma_pkg.sv
// Shared types and constants for the word-copy DMA engine.
// Optional completion interrupt is enabled with the DMA_IRQ_EN macro.
package dma_pkg;

    localparam int DMA_SRC_W = 32;
    localparam int DMA_DST_W = 16;
    localparam int DMA_CNT_W = 16;

    localparam logic [1:0] DMA_MODE_SRC_L = 2'd0;
    localparam logic [1:0] DMA_MODE_SRC_U = 2'd1;
    localparam logic [1:0] DMA_MODE_DST   = 2'd2;
    localparam logic [1:0] DMA_MODE_AMT   = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        FETCH = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } dma_state_t;

    // AMT readback word: busy flag in bit 15 above the remaining count.
    function automatic logic [15:0] amt_word(input logic busy, input logic [14:0] cnt);
        return {busy, cnt};
    endfunction

endpackage

// File: rtl/dma_regfile.sv
// DMA address/count registers with per-word stepping and registered readback.
// Writes are gated by the controller; stepping happens once per written word.
module dma_regfile
    import dma_pkg::*;
#(
    parameter int SRC_W = DMA_SRC_W,
    parameter int DST_W = DMA_DST_W,
    parameter int CNT_W = DMA_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [1:0]       i_mode,
    input  logic [15:0]      i_wdata,
    input  logic             i_step,
    input  logic             i_rd_en,
    input  logic             i_busy,
    output logic [SRC_W-1:0] o_src,
    output logic [DST_W-1:0] o_dst,
    output logic [CNT_W-1:0] o_cnt,
    output logic [15:0]      o_rdata
);

    localparam int SRC_HI_W = SRC_W - 16;

    logic [SRC_W-1:0] r_src;
    logic [DST_W-1:0] r_dst;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_rdata;
    logic [15:0]      w_rsel;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_src <= '0;
            r_dst <= '0;
            r_cnt <= '0;
        end else if (i_wr_en) begin
            unique case (i_mode)
                DMA_MODE_SRC_L: r_src[15:0]       <= i_wdata;
                DMA_MODE_SRC_U: r_src[SRC_W-1:16] <= i_wdata[SRC_HI_W-1:0];
                DMA_MODE_DST:   r_dst             <= i_wdata[DST_W-1:0];
                default:        r_cnt             <= i_wdata[CNT_W-1:0];
            endcase
        end else if (i_step) begin
            // Full-width increments: carry into the upper source half, natural wrap.
            r_src <= r_src + SRC_W'(1);
            r_dst <= r_dst + DST_W'(1);
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        w_rsel = '0;
        unique case (i_mode)
            DMA_MODE_SRC_L: w_rsel = r_src[15:0];
            DMA_MODE_SRC_U: w_rsel = 16'(r_src[SRC_W-1:16]);
            DMA_MODE_DST:   w_rsel = 16'(r_dst);
            default:        w_rsel = amt_word(i_busy, 15'(r_cnt));
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= i_rd_en ? w_rsel : '0;
        end
    end

    assign o_src   = r_src;
    assign o_dst   = r_dst;
    assign o_cnt   = r_cnt;
    assign o_rdata = r_rdata;

endmodule

// File: rtl/dma_controller.sv
// Word-copy DMA engine: bus request, source req/ack fetch, destination write.
// Define DMA_IRQ_EN to add the dma_irq completion flag port.
module dma_controller
    import dma_pkg::*;
#(
    parameter int SRC_W = DMA_SRC_W,
    parameter int DST_W = DMA_DST_W,
    parameter int CNT_W = DMA_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dma_en,
    input  logic [1:0]       dma_mode,
    input  logic             memwrite,
    input  logic [15:0]      writedata,
    output logic [15:0]      dma_rdata,
    output logic             busy,
    output logic             bus_req,
    input  logic             bus_grant,
    output logic [SRC_W-1:0] src_addr,
    output logic             src_req,
    input  logic             src_ack,
    input  logic [15:0]      src_data,
    output logic [DST_W-1:0] dst_addr,
    output logic             dst_write,
    output logic [15:0]      dst_data
`ifdef DMA_IRQ_EN
    ,
    output logic             dma_irq
`endif
);

    dma_state_t       r_state;
    dma_state_t       w_next;
    logic [15:0]      r_data;
    logic [CNT_W-1:0] w_cnt;
    logic             w_wr_acc;
    logic             w_start;
    logic             w_last;
    logic             w_busy;
    logic             w_src_req;
    logic             w_dst_write;

    assign w_wr_acc = dma_en & memwrite & (r_state == IDLE);
    assign w_start  = w_wr_acc && (dma_mode == DMA_MODE_AMT) && (writedata[CNT_W-1:0] != '0);
    assign w_last   = (w_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The bus stays requested through DONE so busy and bus_req drop on the edge back to IDLE.
    always_comb begin
        w_next      = r_state;
        w_busy      = 1'b0;
        w_src_req   = 1'b0;
        w_dst_write = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_start) w_next = REQ;
            end
            REQ: begin
                w_busy = 1'b1;
                if (bus_grant) w_next = FETCH;
            end
            FETCH: begin
                w_busy    = 1'b1;
                w_src_req = 1'b1;
                if (src_ack) w_next = WRITE;
            end
            WRITE: begin
                w_busy      = 1'b1;
                w_dst_write = 1'b1;
                if (w_last)         w_next = DONE;
                else if (bus_grant) w_next = FETCH;
                else                w_next = REQ;
            end
            DONE: begin
                w_busy = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data <= '0;
        end else if ((r_state == FETCH) && src_ack) begin
            r_data <= src_data;
        end
    end

    dma_regfile #(
        .SRC_W(SRC_W),
        .DST_W(DST_W),
        .CNT_W(CNT_W)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .i_wr_en(w_wr_acc),
        .i_mode (dma_mode),
        .i_wdata(writedata),
        .i_step (w_dst_write),
        .i_rd_en(dma_en),
        .i_busy (w_busy),
        .o_src  (src_addr),
        .o_dst  (dst_addr),
        .o_cnt  (w_cnt),
        .o_rdata(dma_rdata)
    );

`ifdef DMA_IRQ_EN
    logic r_irq;

    // Set wins over a same-cycle clear so a completion is never missed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_irq <= 1'b0;
        end else if ((r_state == WRITE) && (w_next == DONE)) begin
            r_irq <= 1'b1;
        end else if (dma_en && (dma_mode == DMA_MODE_AMT)) begin
            r_irq <= 1'b0;
        end
    end

    assign dma_irq = r_irq;
`endif

    assign busy      = w_busy;
    assign bus_req   = w_busy;
    assign src_req   = w_src_req;
    assign dst_write = w_dst_write;
    assign dst_data  = r_data;

endmodule

// File: tb/tb_dma_controller.sv
// Scoreboard bench for dma_controller: expected writes are queued when a transfer
// is programmed and matched against every dst_write pulse.
module tb_dma_controller;
    import dma_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, dma_en, memwrite;
    logic [1:0]  dma_mode;
    logic [15:0] writedata;
    logic [15:0] dma_rdata;
    logic        busy, bus_req, bus_grant;
    logic [31:0] src_addr;
    logic        src_req, src_ack;
    logic [15:0] src_data;
    logic [15:0] dst_addr;
    logic        dst_write;
    logic [15:0] dst_data;
`ifdef DMA_IRQ_EN
    logic        dma_irq;
`endif

    logic gnt_en, ack_en;

    function automatic logic [15:0] src_model(input logic [31:0] a);
        return {a[7:0], a[15:8]} ^ a[31:16] ^ 16'h5A3C;
    endfunction

    assign bus_grant = bus_req & gnt_en;
    assign src_ack   = src_req & ack_en;
    assign src_data  = src_model(src_addr);

    dma_controller dut (
        .clk      (clk),
        .rst      (rst),
        .dma_en   (dma_en),
        .dma_mode (dma_mode),
        .memwrite (memwrite),
        .writedata(writedata),
        .dma_rdata(dma_rdata),
        .busy     (busy),
        .bus_req  (bus_req),
        .bus_grant(bus_grant),
        .src_addr (src_addr),
        .src_req  (src_req),
        .src_ack  (src_ack),
        .src_data (src_data),
        .dst_addr (dst_addr),
        .dst_write(dst_write),
        .dst_data (dst_data)
`ifdef DMA_IRQ_EN
        ,
        .dma_irq  (dma_irq)
`endif
    );

    typedef struct {
        logic [15:0] dst;
        logic [31:0] src;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_writes = 0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b1 && dst_write === 1'b1) begin
            n_writes++;
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected got dst=%h data=%h src=%h, no write expected",
                         dst_addr, dst_data, src_addr);
            end else begin
                e = sb.pop_front();
                if (dst_addr !== e.dst || dst_data !== e.data || src_addr !== e.src)
                    $display("FAIL sb_write got dst=%h data=%h src=%h exp dst=%h data=%h src=%h",
                             dst_addr, dst_data, src_addr, e.dst, e.data, e.src);
                else
                    n_pass++;
            end
        end
    end

    task automatic push_words(input logic [31:0] src, input logic [15:0] dst, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.src  = src + 32'(i);
            e.dst  = dst + 16'(i);
            e.data = src_model(e.src);
            sb.push_back(e);
        end
    endtask

    task automatic reg_write(input logic [1:0] m, input logic [15:0] d);
        @(negedge clk);
        dma_en = 1'b1; memwrite = 1'b1; dma_mode = m; writedata = d;
        @(negedge clk);
        dma_en = 1'b0; memwrite = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] m, output logic [15:0] d);
        @(negedge clk);
        dma_en = 1'b1; memwrite = 1'b0; dma_mode = m;
        @(negedge clk);
        dma_en = 1'b0;
        d = dma_rdata;
    endtask

    task automatic program_regs(input logic [31:0] src, input logic [15:0] dst);
        reg_write(DMA_MODE_SRC_L, src[15:0]);
        reg_write(DMA_MODE_SRC_U, src[31:16]);
        reg_write(DMA_MODE_DST, dst);
    endtask

    task automatic wait_idle(input int maxc, output int cyc);
        cyc = 0;
        while (busy !== 1'b0 && cyc < maxc) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; dma_en = 1'b0; memwrite = 1'b0; dma_mode = 2'd0; writedata = '0;
        gnt_en = 1'b0; ack_en = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, bus_req, src_req, dst_write} !== 4'b0000)
            $display("FAIL reset_ctrl got %b exp 0000", {busy, bus_req, src_req, dst_write});
        else n_pass++;
        n_checks++;
        if ({src_addr, dst_addr, dst_data, dma_rdata} !== '0)
            $display("FAIL reset_data got src=%h dst=%h data=%h rd=%h exp all 0",
                     src_addr, dst_addr, dst_data, dma_rdata);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int w0, cyc;
        logic [15:0] rd;
        gnt_en = 1'b1; ack_en = 1'b1;
        program_regs(32'h0001_FFFE, 16'h2400);
        push_words(32'h0001_FFFE, 16'h2400, 3);
        w0 = n_writes;
        reg_write(DMA_MODE_AMT, 16'd3);
        n_checks++;
        if ({busy, bus_req} !== 2'b11) $display("FAIL basic_start got %b exp 11", {busy, bus_req});
        else n_pass++;
        wait_idle(40, cyc);
        n_checks++;
        if (cyc != 8 || bus_req !== 1'b0)
            $display("FAIL basic_cycles got %0d req=%b exp 8 req=0", cyc, bus_req);
        else n_pass++;
        n_checks++;
        if (n_writes - w0 != 3 || sb.size() != 0)
            $display("FAIL basic_count got %0d left=%0d exp 3 left=0", n_writes - w0, sb.size());
        else n_pass++;
        reg_read(DMA_MODE_SRC_L, rd);
        n_checks++;
        if (rd !== 16'h0001) $display("FAIL basic_rd_srcl got %h exp 0001", rd); else n_pass++;
        reg_read(DMA_MODE_SRC_U, rd);
        n_checks++;
        if (rd !== 16'h0002) $display("FAIL basic_rd_srcu got %h exp 0002", rd); else n_pass++;
        reg_read(DMA_MODE_DST, rd);
        n_checks++;
        if (rd !== 16'h2403) $display("FAIL basic_rd_dst got %h exp 2403", rd); else n_pass++;
    endtask

    task automatic test_zero_amt;
        int w0;
        logic [15:0] rd;
        w0 = n_writes;
        reg_write(DMA_MODE_AMT, 16'd0);
        n_checks++;
        if ({busy, bus_req} !== 2'b00) $display("FAIL zero_start got %b exp 00", {busy, bus_req});
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || n_writes != w0)
            $display("FAIL zero_idle got busy=%b writes=%0d exp 0/0", busy, n_writes - w0);
        else n_pass++;
        reg_read(DMA_MODE_AMT, rd);
        n_checks++;
        if (rd !== 16'h0000) $display("FAIL zero_rd_amt got %h exp 0000", rd); else n_pass++;
    endtask

    task automatic test_dst_wrap;
        int w0, cyc;
        logic [15:0] rd;
        gnt_en = 1'b1; ack_en = 1'b1;
        program_regs(32'h0000_0100, 16'hFFFF);
        push_words(32'h0000_0100, 16'hFFFF, 2);
        w0 = n_writes;
        reg_write(DMA_MODE_AMT, 16'd2);
        wait_idle(40, cyc);
        n_checks++;
        if (cyc != 6 || n_writes - w0 != 2 || sb.size() != 0)
            $display("FAIL wrap_done got cyc=%0d n=%0d left=%0d exp 6/2/0", cyc, n_writes - w0, sb.size());
        else n_pass++;
        reg_read(DMA_MODE_DST, rd);
        n_checks++;
        if (rd !== 16'h0001) $display("FAIL wrap_rd_dst got %h exp 0001", rd); else n_pass++;
    endtask

    task automatic test_grant_stall;
        int w0, cyc;
        logic bad, seen;
        gnt_en = 1'b0; ack_en = 1'b1;
        program_regs(32'h0030_0010, 16'h1000);
        push_words(32'h0030_0010, 16'h1000, 4);
        w0 = n_writes;
        reg_write(DMA_MODE_AMT, 16'd4);
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (src_req !== 1'b0 || bus_req !== 1'b1) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL stall_wait got req/src_req wrong, exp bus_req=1 src_req=0");
        else n_pass++;
        gnt_en = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (dst_write === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) $display("FAIL stall_first got no dst_write exp one within 20 cycles");
        else n_pass++;
        gnt_en = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus_req !== 1'b1 || src_req !== 1'b0 || dst_write !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL stall_drop got activity without grant exp bus_req held, idle bus");
        else n_pass++;
        gnt_en = 1'b1;
        wait_idle(60, cyc);
        n_checks++;
        if (busy !== 1'b0 || n_writes - w0 != 4 || sb.size() != 0)
            $display("FAIL stall_count got busy=%b n=%0d left=%0d exp 0/4/0", busy, n_writes - w0, sb.size());
        else n_pass++;
    endtask

    task automatic test_busy_ignore;
        int w0, cyc;
        logic [15:0] rd;
        gnt_en = 1'b1; ack_en = 1'b1;
        program_regs(32'h0005_0000, 16'h3000);
        push_words(32'h0005_0000, 16'h3000, 5);
        w0 = n_writes;
        reg_write(DMA_MODE_AMT, 16'd5);
        reg_write(DMA_MODE_SRC_L, 16'h1234);
        reg_write(DMA_MODE_AMT, 16'd9);
        wait_idle(60, cyc);
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || n_writes - w0 != 5 || sb.size() != 0)
            $display("FAIL ignore_count got busy=%b n=%0d left=%0d exp 0/5/0", busy, n_writes - w0, sb.size());
        else n_pass++;
        reg_read(DMA_MODE_SRC_L, rd);
        n_checks++;
        if (rd !== 16'h0005) $display("FAIL ignore_rd_srcl got %h exp 0005", rd); else n_pass++;
        reg_read(DMA_MODE_AMT, rd);
        n_checks++;
        if (rd !== 16'h0000) $display("FAIL ignore_rd_amt got %h exp 0000", rd); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int w0;
        logic seen;
        logic [15:0] rd;
        gnt_en = 1'b1; ack_en = 1'b1;
        program_regs(32'h0000_0200, 16'h4000);
        push_words(32'h0000_0200, 16'h4000, 1);
        w0 = n_writes;
        reg_write(DMA_MODE_AMT, 16'd5);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (dst_write === 1'b1) seen = 1'b1;
        end
        ack_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (!seen || src_req !== 1'b1)
            $display("FAIL rstmid_fetch got seen=%b src_req=%b exp 1/1", seen, src_req);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, bus_req, src_req, dst_write} !== 4'b0000)
            $display("FAIL rstmid_ctrl got %b exp 0000", {busy, bus_req, src_req, dst_write});
        else n_pass++;
        n_checks++;
        if ({src_addr, dst_addr, dst_data, dma_rdata} !== '0)
            $display("FAIL rstmid_data got src=%h dst=%h data=%h rd=%h exp all 0",
                     src_addr, dst_addr, dst_data, dma_rdata);
        else n_pass++;
        rst = 1'b1; ack_en = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || n_writes - w0 != 1 || sb.size() != 0)
            $display("FAIL rstmid_idle got busy=%b n=%0d left=%0d exp 0/1/0", busy, n_writes - w0, sb.size());
        else n_pass++;
        reg_read(DMA_MODE_AMT, rd);
        n_checks++;
        if (rd !== 16'h0000) $display("FAIL rstmid_rd_amt got %h exp 0000", rd); else n_pass++;
    endtask

`ifdef DMA_IRQ_EN
    task automatic test_irq;
        int cyc;
        logic [15:0] rd;
        gnt_en = 1'b1; ack_en = 1'b1;
        n_checks++;
        if (dma_irq !== 1'b0) $display("FAIL irq_init got %b exp 0", dma_irq); else n_pass++;
        program_regs(32'h0000_0010, 16'h0010);
        push_words(32'h0000_0010, 16'h0010, 1);
        reg_write(DMA_MODE_AMT, 16'd1);
        wait_idle(40, cyc);
        repeat (2) @(negedge clk);
        n_checks++;
        if (dma_irq !== 1'b1) $display("FAIL irq_set got %b exp 1", dma_irq); else n_pass++;
        reg_read(DMA_MODE_AMT, rd);
        n_checks++;
        if (dma_irq !== 1'b0) $display("FAIL irq_clear got %b exp 0", dma_irq); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_amt();
        test_dst_wrap();
        test_grant_stall();
        test_busy_ignore();
        test_reset_mid();
`ifdef DMA_IRQ_EN
        test_irq();
`endif
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
